// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared helpers for the pipelined ripple-carry adder: chunk placement
//   and the carry/overflow relations used by the stage that owns the MSB.
//   No ports; imported by pipelined_adder and pipelined_adder_stage.
package pipelined_adder_pkg;

  // Bit index of the least significant bit of chunk idx.
  function automatic int chunk_lo(input int idx, input int chunk);
    return idx * chunk;
  endfunction

  // The carry into a bit position is recoverable from its operands and
  // its sum bit: s = a ^ b ^ cin, hence cin = a ^ b ^ s.
  function automatic logic carry_into_msb(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
    return a_msb ^ b_msb ^ s_msb;
  endfunction

  // Two's-complement overflow: carry into the MSB differs from carry out.
  function automatic logic signed_ovf(input logic cin_msb, input logic cout);
    return cin_msb ^ cout;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// pipelined_adder_stage
//   One pipeline slice of the adder. Adds chunk IDX of a/b together with
//   the carry arriving from the previous slice and registers the partially
//   built sum, the untouched operand bits and the carry out of the chunk.
//   The slice holding bit WIDTH-1 also registers the signed overflow flag.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   advance_i    this slice may load (it is empty or its successor moves)
//   valid_i      upstream slice (or the input port) holds a transaction
//   a_i, b_i     operands as carried so far
//   sum_i        lower sum bits already produced by earlier slices
//   carry_i      carry into this chunk
//   valid_o      this slice holds a transaction
//   a_o, b_o     registered operands for the next slice
//   sum_o        registered sum with this chunk filled in
//   carry_o      registered carry out of this chunk
//   ovf_o        registered signed overflow (meaningful only in the MSB slice)
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHUNK     = 4,
  parameter int IDX       = 0,
  parameter bit HOLDS_MSB = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int LO = chunk_lo(IDX, CHUNK);

  logic [CHUNK:0]     chunk_add;
  logic [WIDTH-1:0]   sum_d;
  logic               ovf_d;

  logic               valid_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               ovf_q;

  always_comb begin
    chunk_add = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_i};
    sum_d = sum_i;
    sum_d[LO +: CHUNK] = chunk_add[CHUNK-1:0];
    ovf_d = 1'b0;
    if (HOLDS_MSB) begin
      ovf_d = signed_ovf(carry_into_msb(a_i[WIDTH-1], b_i[WIDTH-1], sum_d[WIDTH-1]),
                         chunk_add[CHUNK]);
    end
  end

  // Data registers only load when a real transaction moves in, so the
  // last slice keeps presenting the previous result after it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        a_q     <= a_i;
        b_q     <= b_i;
        sum_q   <= sum_d;
        carry_q <= chunk_add[CHUNK];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined ripple-carry adder with valid/ready handshakes on both sides.
//   The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK bits, one
//   register slice per chunk; throughput is one result per cycle and the
//   latency is STAGES cycles when the output is not stalled.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for a, b, ci
//   a, b, ci             operands and carry into bit 0
//   out_valid/out_ready  output handshake
//   s                    (a + b + ci) mod 2^WIDTH
//   co                   carry out of bit WIDTH-1
//   ovf                  signed overflow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH < 1) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Index 0 is the input port; index k+1 is the register of slice k.
  logic [WIDTH-1:0] a_pipe     [STAGES+1];
  logic [WIDTH-1:0] b_pipe     [STAGES+1];
  logic [WIDTH-1:0] sum_pipe   [STAGES+1];
  logic             carry_pipe [STAGES+1];
  logic             valid_pipe [STAGES+1];
  logic             ovf_stage  [STAGES];
  // advance[k] lets slice k load; advance[STAGES] is the downstream ready.
  logic             advance    [STAGES+1];
  logic             unused_tail;

  assign a_pipe[0]     = a;
  assign b_pipe[0]     = b;
  assign sum_pipe[0]   = '0;
  assign carry_pipe[0] = ci;
  assign valid_pipe[0] = in_valid;

  // Ready chain, evaluated from the output backwards: a slice can load if
  // it is empty (bubble collapse) or if its own content is moving on.
  always_comb begin
    for (int k = 0; k <= STAGES; k++) begin
      advance[k] = 1'b0;
    end
    advance[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = !valid_pipe[k+1] || advance[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_stage #(
      .WIDTH     (WIDTH),
      .CHUNK     (CHUNK),
      .IDX       (k),
      .HOLDS_MSB (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance[k]),
      .valid_i   (valid_pipe[k]),
      .a_i       (a_pipe[k]),
      .b_i       (b_pipe[k]),
      .sum_i     (sum_pipe[k]),
      .carry_i   (carry_pipe[k]),
      .valid_o   (valid_pipe[k+1]),
      .a_o       (a_pipe[k+1]),
      .b_o       (b_pipe[k+1]),
      .sum_o     (sum_pipe[k+1]),
      .carry_o   (carry_pipe[k+1]),
      .ovf_o     (ovf_stage[k])
    );
  end

  assign in_ready  = advance[0];
  assign out_valid = valid_pipe[STAGES];
  assign s         = sum_pipe[STAGES];
  assign co        = carry_pipe[STAGES];
  assign ovf       = ovf_stage[STAGES-1];

  // Operands leaving the last slice and overflow flags of the inner slices
  // have no consumer; synthesis removes them.
  always_comb begin
    unused_tail = (^a_pipe[STAGES]) ^ (^b_pipe[STAGES]);
    for (int k = 0; k < STAGES - 1; k++) begin
      unused_tail = unused_tail ^ ovf_stage[k];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv8 = 1'b0, ir8, ci8 = 1'b0, ov8, or8 = 1'b1, co8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       iv3 = 1'b0, ir3, ci3 = 1'b0, ov3, or3 = 1'b1, co3, ovf3;
  logic [2:0] a3 = '0, b3 = '0, s3;

  int checks = 0;
  int failures = 0;
  int pops8 = 0;
  int pops3 = 0;
  logic [9:0] exp8[$];
  logic [9:0] exp3[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .ci(ci8), .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8));

  pipelined_adder #(.WIDTH(3), .STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .ci(ci3), .out_valid(ov3), .out_ready(or3), .s(s3), .co(co3), .ovf(ovf3));

  // Reference: plain integer addition; result packed as {ovf, co, s[7:0]}.
  function automatic logic [9:0] ref_add(input int w, input int unsigned a,
                                         input int unsigned b, input int unsigned c);
    int unsigned full;
    int unsigned sm;
    bit co, sa, sb, ss, ov;
    full = a + b + c;
    sm   = full & ((32'd1 << w) - 32'd1);
    co   = ((full >> w) & 32'd1) != 0;
    sa   = ((a >> (w - 1)) & 32'd1) != 0;
    sb   = ((b >> (w - 1)) & 32'd1) != 0;
    ss   = ((sm >> (w - 1)) & 32'd1) != 0;
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, sm[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 8-bit instance: drive, settle, score, advance.
  task automatic cyc8(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                      input bit ic, input bit ordy, output bit acc);
    logic [9:0] e;
    iv8 = iv; a8 = ia; b8 = ib; ci8 = ic; or8 = ordy;
    #1;
    acc = iv && ir8;
    if (ov8 && ordy) begin
      pops8++;
      check("u8_expected_output", 32'(exp8.size() != 0), 32'(1));
      if (exp8.size() != 0) begin
        e = exp8.pop_front();
        check("u8_s", 32'(s8), 32'(e[7:0]));
        check("u8_co", 32'(co8), 32'(e[8]));
        check("u8_ovf", 32'(ovf8), 32'(e[9]));
      end
    end
    if (acc) exp8.push_back(ref_add(8, 32'(ia), 32'(ib), 32'(ic)));
    @(posedge clk); #1;
  endtask

  task automatic cyc3(input bit iv, input logic [2:0] ia, input logic [2:0] ib,
                      input bit ic, input bit ordy, output bit acc);
    logic [9:0] e;
    iv3 = iv; a3 = ia; b3 = ib; ci3 = ic; or3 = ordy;
    #1;
    acc = iv && ir3;
    if (ov3 && ordy) begin
      pops3++;
      check("u3_expected_output", 32'(exp3.size() != 0), 32'(1));
      if (exp3.size() != 0) begin
        e = exp3.pop_front();
        check("u3_s", 32'(s3), 32'(e[2:0]));
        check("u3_co", 32'(co3), 32'(e[8]));
        check("u3_ovf", 32'(ovf3), 32'(e[9]));
      end
    end
    if (acc) exp3.push_back(ref_add(3, 32'(ia), 32'(ib), 32'(ic)));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int p0;
    logic [9:0] head;
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    bit         sc [4];

    // Reset values, checked while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov8), 32'(0));
    check("rst_s", 32'(s8), 32'(0));
    check("rst_co", 32'(co8), 32'(0));
    check("rst_ovf", 32'(ovf8), 32'(0));
    check("rst_in_ready", 32'(ir8), 32'(1));
    check("rst_u3_out_valid", 32'(ov3), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(ir8), 32'(1));

    // 0 + 0 + 0, latency of two cycles.
    cyc8(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t1_accept", 32'(acc), 32'(1));
    check("t1_not_yet_valid", 32'(ov8), 32'(0));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t1_valid_after_2", 32'(ov8), 32'(1));
    check("t1_s", 32'(s8), 32'(8'h00));
    check("t1_co", 32'(co8), 32'(0));
    check("t1_ovf", 32'(ovf8), 32'(0));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // Carry across the chunk boundary, then signed overflow.
    cyc8(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, acc);
    cyc8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, acc);
    check("t2a_valid", 32'(ov8), 32'(1));
    check("t2a_s", 32'(s8), 32'(8'h00));
    check("t2a_co", 32'(co8), 32'(1));
    check("t2a_ovf", 32'(ovf8), 32'(0));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t2b_valid", 32'(ov8), 32'(1));
    check("t2b_s", 32'(s8), 32'(8'h80));
    check("t2b_co", 32'(co8), 32'(0));
    check("t2b_ovf", 32'(ovf8), 32'(1));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t2_drained", 32'(exp8.size()), 32'(0));

    // Back-to-back stream of four, results on consecutive cycles.
    sa = '{8'h01, 8'h10, 8'h80, 8'hF0};
    sb = '{8'h01, 8'h10, 8'h80, 8'h0F};
    sc = '{1'b0, 1'b0, 1'b0, 1'b1};
    p0 = pops8;
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b1, sa[i], sb[i], sc[i], 1'b1, acc);
      check("t3_accept", 32'(acc), 32'(1));
    end
    for (int i = 0; i < 2; i++) begin
      check("t3_consecutive_valid", 32'(ov8), 32'(1));
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    end
    check("t3_pop_count", 32'(pops8 - p0), 32'(4));
    check("t3_drained", 32'(exp8.size()), 32'(0));

    // Backpressure: only two fit, output holds, then a shift-and-accept.
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b1, 8'(8'h21 + i), 8'(8'h11 * i), 1'b0, 1'b0, acc);
      if (acc) n++;
    end
    check("t4_accepted", 32'(n), 32'(2));
    check("t4_in_ready_low", 32'(ir8), 32'(0));
    head = exp8[0];
    for (int i = 0; i < 3; i++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
      check("t4_hold_valid", 32'(ov8), 32'(1));
      check("t4_hold_s", 32'(s8), 32'(head[7:0]));
      check("t4_hold_co", 32'(co8), 32'(head[8]));
    end
    cyc8(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, acc);
    check("t4_full_shift_accept", 32'(acc), 32'(1));
    for (int i = 0; i < 6 && exp8.size() != 0; i++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    end
    check("t4_drained", 32'(exp8.size()), 32'(0));

    // Reset with a full pipeline: flushed, no stale output afterwards.
    cyc8(1'b1, 8'h99, 8'h11, 1'b0, 1'b0, acc);
    cyc8(1'b1, 8'h42, 8'h24, 1'b1, 1'b0, acc);
    check("t5_full", 32'(ov8), 32'(1));
    iv8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_out_valid", 32'(ov8), 32'(0));
    check("t5_async_s", 32'(s8), 32'(0));
    check("t5_async_co", 32'(co8), 32'(0));
    check("t5_async_ovf", 32'(ovf8), 32'(0));
    exp8.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc8(1'b1, 8'h05, 8'h03, 1'b0, 1'b1, acc);
    check("t5_accept", 32'(acc), 32'(1));
    check("t5_no_stale", 32'(ov8), 32'(0));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t5_valid", 32'(ov8), 32'(1));
    check("t5_s", 32'(s8), 32'(8'h08));
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("t5_single_result", 32'(ov8), 32'(0));

    // Random traffic on the 8-bit instance.
    for (int i = 0; i < 200; i++) begin
      cyc8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 10 && exp8.size() != 0; i++) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    end
    check("rand8_drained", 32'(exp8.size()), 32'(0));

    // WIDTH=3, STAGES=3: every a, b, ci with random out_ready.
    for (int i = 0; i < 128; i++) begin
      n = 0;
      do begin
        cyc3(1'b1, 3'(i), 3'(i >> 3), 1'(i >> 6), 1'($urandom_range(0, 1)), acc);
        n++;
      end while (!acc && n < 20);
      check("u3_accept_in_budget", 32'(acc), 32'(1));
    end
    iv3 = 1'b0;
    for (int i = 0; i < 20 && exp3.size() != 0; i++) begin
      cyc3(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, acc);
    end
    check("u3_drained", 32'(exp3.size()), 32'(0));
    check("u3_pop_count", 32'(pops3), 32'(128));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder. It is the sequential successor to the single-bit full adder. The carry chain is split into STAGES equal chunks, with one register stage per chunk. Inputs and outputs use valid/ready handshakes, so it sits directly in streaming datapaths with backpressure at 1 result/cycle throughput.

Parameters:
WIDTH, 8, operand/sum width in bits (>=1).
STAGES, 2, number of pipeline stages; WIDTH % STAGES must be 0 (elaboration-time error otherwise).
CHUNK (localparam), WIDTH/STAGES, bits added per stage.

Ports:
clk  in  1  rising-edge clock, single clock domain.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands a/b/ci valid.
in_ready  out  1  block can accept this cycle.
a  in  WIDTH  operand A, unsigned or two's complement.
b  in  WIDTH  operand B.
ci  in  1  carry in to bit 0.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
s  out  WIDTH  sum, (a+b+ci) mod 2^WIDTH.
co  out  1  carry out of bit WIDTH-1.
ovf  out  1  signed overflow = carry into MSB XOR co.

Behaviour:
- Reset (async assert, sync-safe release): all stage valid bits=0, out_valid=0, s=0, co=0, ovf=0. in_ready=1 immediately after reset.
- Reset mid-operation discards all in-flight transactions; nothing is replayed after release.
- Transfer occurs on a rising edge where valid && ready. Input acceptance: in_valid && in_ready.
- Stage k (0..STAGES-1) state:
  - valid_k
  - lower sum bits [CHUNK*(k+1)-1:0], already computed
  - carry out of chunk k
  - untouched upper a/b bits
  - MSB carry-in, latched in the stage that holds bit WIDTH-1
- Stage 0 adds chunk 0 of a,b with ci. Stage k adds chunk k using the registered carry of stage k-1.
- Last stage registers drive s/co/ovf/out_valid directly; no combinational path from a/b to s.
- Latency: result visible STAGES cycles after acceptance when out_ready held high.
- Stall rule: stage k advances when !valid_k || advance_{k+1}. Last stage advances when !out_valid || out_ready. in_ready = stage-0 advance condition.
  - in_ready may depend combinationally on out_ready (ready chain); this is acceptable.
- Bubbles collapse: an empty stage accepts new data even while later stages are stalled.
- While out_valid && !out_ready: s, co, ovf held stable. Each stage register holds its contents when not advancing.
- Capacity is STAGES transactions. Full pipeline with out_ready=0 gives in_ready=0.
- Ordering strictly FIFO; no drop, no duplication.
- Simultaneous out_ready and in_valid with full pipeline: all stages shift, and the new input is accepted in the same cycle.
- Edge cases:
  - STAGES=1: single registered adder, latency 1.
  - WIDTH=STAGES: one bit per stage.

Decomposition:
- No shared package needed; CHUNK and the divisibility check are local parameters.
- One natural sub-module: adder_stage. It holds the CHUNK-bit carry-propagate add plus the stage register and the valid/advance logic, parametrised by CHUNK, WIDTH and stage index.
- pipelined_adder generates STAGES instances and chains the carry/valid/advance signals between them.

Test Plan:
1. WIDTH=8,STAGES=2: a=0x00,b=0x00,ci=0 -> after 2 cycles out_valid=1, s=0x00, co=0, ovf=0.
2. a=0xFF,b=0x00,ci=1 (carry crosses chunk boundary) -> s=0x00, co=1, ovf=0. Also a=0x7F,b=0x01,ci=0 -> s=0x80, co=0, ovf=1.
3. Stream of 4 transactions (0x01+0x01, 0x10+0x10, 0x80+0x80, 0xF0+0x0F,ci=1), out_ready=1 -> results 0x02, 0x20, 0x00/co=1, 0x00/co=1 on consecutive cycles, in order.
4. Backpressure: hold out_ready=0 with in_valid=1 -> exactly 2 accepted, then in_ready=0. Output stable for 3 cycles. On out_ready=1 both results drain in order, with no loss or duplicate.
5. Assert rst_n=0 mid-stream with the pipeline full -> out_valid/s/co/ovf=0 asynchronously. After release, first new sum 0x05+0x03=0x08 is correct, with no stale output.
6. WIDTH=3,STAGES=3: exhaustive sweep of all a,b,ci (128 vectors) with random out_ready -> every result matches the reference a+b+ci, including co and ovf.
